// File: rtl/fifod2mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifod2mac_pkg : shared states and framing constants for fifod2mac    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifod2mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_INFO = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0]  c_HEAD_BYTE = 8'hAA;
  localparam int unsigned c_MIN_LEN   = 3;
  // head + dev_info + checksum bytes wrapped around the payload
  localparam int unsigned c_FRAME_OVH = 3;

  function automatic int unsigned payload_len(input int unsigned len,
                                              input int unsigned min_len);
    int unsigned clamped;
    clamped = (len < min_len) ? min_len : len;
    return clamped - c_FRAME_OVH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifod2mac_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifod2mac_rd_pipe : FIFO D read-ahead counter and 1-cycle valid flag |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifod2mac_rd_pipe #(
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_empty,
  input  logic [LEN_W-1:0] i_n,
  output logic             o_rxen,
  output logic             o_dv,
  output logic             o_last
);

  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_emitted;
  logic             r_dv;

  assign o_rxen = i_en && (r_issued < i_n) && !i_empty;
  assign o_dv   = r_dv;
  assign o_last = r_dv && (r_emitted == (i_n - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued  <= '0;
      r_emitted <= '0;
      r_dv      <= 1'b0;
    end else if (i_clear) begin
      r_issued  <= '0;
      r_emitted <= '0;
      r_dv      <= 1'b0;
    end else begin
      if (o_rxen) r_issued <= r_issued + LEN_W'(1);
      if (r_dv)   r_emitted <= r_emitted + LEN_W'(1);
      r_dv <= o_rxen;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifod2mac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifod2mac : drains one FIFO D frame to the MAC on the fs/fd handshake|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifod2mac
  import fifod2mac_pkg::*;
#(
  parameter logic [7:0]  HEAD_BYTE = c_HEAD_BYTE,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MIN_LEN   = c_MIN_LEN
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              fs_fifod2mac,
  output logic              fd_fifod2mac,
  input  logic [LEN_W-1:0]  eth_tx_len,
  input  logic [7:0]        dev_info,
  input  logic [DATA_W-1:0] fifod_rxd,
  input  logic              fifod_empty,
  output logic              fifod_rxen,
  output logic [DATA_W-1:0] mac_txd,
  output logic              mac_txv,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_n;
  logic [7:0]          r_info;
  logic [DATA_W-1:0]   r_chk;
  logic                w_accept;
  logic                w_rd_en;
  logic                w_dv;
  logic                w_last;

  assign w_accept = (r_state == S_IDLE) && fs_fifod2mac;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_info  <= '0;
      r_chk   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_n    <= LEN_W'(payload_len(32'(eth_tx_len), MIN_LEN));
        r_info <= dev_info;
        r_chk  <= '0;
      end else if (w_dv) begin
        r_chk  <= r_chk ^ fifod_rxd;
      end
    end
  end

  // Reads start during INFO so the first payload byte follows dev_info
  // with no bubble.
  always_comb begin
    w_next       = r_state;
    w_rd_en      = 1'b0;
    mac_txd      = '0;
    mac_txv      = 1'b0;
    fd_fifod2mac = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fs_fifod2mac) w_next = S_HEAD;
      end
      S_HEAD: begin
        mac_txd = DATA_W'(HEAD_BYTE);
        mac_txv = 1'b1;
        w_next  = S_INFO;
      end
      S_INFO: begin
        mac_txd = DATA_W'(r_info);
        mac_txv = 1'b1;
        w_rd_en = 1'b1;
        w_next  = (r_n == '0) ? S_CHK : S_DATA;
      end
      S_DATA: begin
        w_rd_en = 1'b1;
        if (w_dv) begin
          mac_txd = fifod_rxd;
          mac_txv = 1'b1;
        end
        if (w_last) w_next = S_CHK;
      end
      S_CHK: begin
        mac_txd = r_chk;
        mac_txv = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        fd_fifod2mac = 1'b1;
        if (!fs_fifod2mac) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  fifod2mac_rd_pipe #(
    .LEN_W(LEN_W)
  ) u_rd_pipe (
    .clk    (sys_clk),
    .rst_n  (rst),
    .i_clear(w_accept),
    .i_en   (w_rd_en),
    .i_empty(fifod_empty),
    .i_n    (r_n),
    .o_rxen (fifod_rxen),
    .o_dv   (w_dv),
    .o_last (w_last)
  );

endmodule
`default_nettype wire

// File: doc/fifod2mac.md
Name: fifod2mac

Overview:
- Responder end of the fs/fd flag handshake for the ADC-to-Ethernet transmit path.
- On fs_fifod2mac it drains one frame's payload from FIFO D (the ADC data FIFO, byte-wide, 1-cycle read latency) and streams a framed byte sequence to the MAC transmit input.
- It signals completion on fd_fifod2mac.
- It sits between FIFO D and the UDP TX/MAC block, paced by the eth_tx_len value from the number decoder.

Parameters:
- HEAD_BYTE, 8'hAA, first byte of every frame
- LEN_W, 12, width of frame length input
- DATA_W, 8, byte width of FIFO and MAC data
- MIN_LEN, 3, minimum emitted frame length (head + dev_info + checksum)

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- fs_fifod2mac  in  1  start flag, level; initiator holds high until it sees fd
- fd_fifod2mac  out  1  done flag, level
- eth_tx_len  in  LEN_W  total frame bytes to emit, including header and checksum
- dev_info  in  8  device/data id byte, sent as frame byte 1
- fifod_rxd  in  DATA_W  FIFO D read data, valid 1 cycle after fifod_rxen
- fifod_empty  in  1  FIFO D empty
- fifod_rxen  out  1  FIFO D read enable
- mac_txd  out  DATA_W  byte to MAC
- mac_txv  out  1  mac_txd valid this cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state IDLE; fd_fifod2mac, fifod_rxen, mac_txv, busy = 0; mac_txd = 0; counters and checksum = 0.
- Frame format:
  - HEAD_BYTE, then dev_info, then N payload bytes from FIFO D, then XOR checksum of the N payload bytes (0x00 if N = 0).
  - N = max(eth_tx_len, MIN_LEN) - 3.
  - eth_tx_len and dev_info are latched on the cycle fs is accepted; later changes are ignored until the next frame.
- States:
  - IDLE: fs sampled high -> HEAD. Latch length and dev_info, clear checksum.
  - HEAD: mac_txd = HEAD_BYTE, mac_txv = 1 -> INFO. First byte therefore appears 1 cycle after fs is sampled.
  - INFO: mac_txd = latched dev_info, mac_txv = 1 -> DATA if N > 0, else CHK.
  - DATA: read-ahead pipeline.
    - fifod_rxen = 1 when reads issued < N and fifod_empty = 0.
    - The byte is emitted (mac_txv = 1) on the following cycle and XORed into the checksum.
    - When fifod_empty = 1, rxen drops and mac_txv goes low for those cycles; no byte is lost or duplicated.
    - Never read past N; rxen must be 0 on the cycle reads issued = N.
    - Leave DATA for CHK on the cycle after the Nth byte is emitted.
  - CHK: mac_txd = checksum, mac_txv = 1 -> DONE.
  - DONE: fd = 1; stay while fs = 1; on fs = 0, fd drops next cycle -> IDLE.
    - If fs is already low on DONE entry, fd is high exactly 1 cycle.
- fs dropping mid-frame is ignored; the frame completes.
- fs re-rising while in DONE is not a new request; the initiator must drop fs and see fd drop first.
- rst asserted mid-frame: immediate return to reset values. Bytes already read from FIFO D are discarded; no partial-frame recovery.
- Counters are LEN_W wide, so there is no wrap for legal lengths. Lengths below MIN_LEN are clamped.
- mac_txv is never high on two bytes of the same value by duplication; each FIFO read maps to exactly one emitted byte.

Decomposition:
- Shared package: state encoding (IDLE, HEAD, INFO, DATA, CHK, DONE), HEAD_BYTE, MIN_LEN, frame-length helper constant (3).
- One natural sub-module: fifod_rd_pipe, the read-ahead counter plus 1-cycle-latency valid tracker (rxen generation, data-valid flag, issued/emitted counts).

Test Plan:
- eth_tx_len = 8, dev_info = 8'h31, FIFO holds 01..05, fs high -> mac bytes AA,31,01,02,03,04,05,01 on consecutive cycles. fd rises the cycle after the checksum and stays high until fs drops, then falls 1 cycle later.
- Same frame with fifod_empty = 1 for 3 cycles after the 2nd payload byte -> mac_txv low 3 cycles, byte order and checksum unchanged, exactly 5 rxen pulses.
- eth_tx_len = 2 -> AA, dev_info, 00 (3 bytes), zero fifod_rxen pulses, fd asserts.
- eth_tx_len = 4095 with FIFO streaming continuously -> 4092 reads, 4095 bytes, no rxen after the last read, checksum matches the reference XOR.
- rst low during the 3rd payload byte -> all outputs 0 asynchronously. After release with fs high, a fresh frame starts with AA.
- fs dropped after HEAD -> frame still completes. fd high for exactly 1 cycle, then IDLE; no second frame.
